result_buffer: RTL and testbench

Assembles two 32-bit adder results into one 64-bit memory word for the write-back path of the calculator datapath. Sits between the adder and the memory-write side of the controller. It captures each sum into the lower or upper half selected by the half-select signal, reports when the word is complete, and hands the 64-bit word to the write stage. Tracks carry-out, overwrite errors and completed-word count for debug and verification.

---
 rtl/result_buffer.sv | 98 +++++++++
 tb/tb_result_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// Assembles two DATA_W adder results into one MEM_WORD_SIZE write-back word.
// Optional build macro RESULT_BUF_CARRY_SAT_EN: a capture with carry stores all-ones.
module result_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int CNT_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        sum_i,
  input  logic                     carry_i,
  input  logic                     half_i,
  input  logic                     consume_i,
  output logic [MEM_WORD_SIZE-1:0] buff_result,
  output logic [1:0]               half_valid_o,
  output logic                     word_ready_o,
  output logic                     ovf_sticky_o,
  output logic                     err_sticky_o,
  output logic [CNT_W-1:0]         word_count_o
);

  // The state encoding is the pair of half-valid bits, so the state register
  // doubles as the half_valid_o debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    LOW   = 2'b01,
    HIGH  = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e                   state_q, state_d;
  logic [MEM_WORD_SIZE-1:0] data_q, data_d;
  logic                     ready_q, ready_d;
  logic                     ovf_q, ovf_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               bits_v;
  logic [DATA_W-1:0]        cap_val;

  always_comb begin
`ifdef RESULT_BUF_CARRY_SAT_EN
    cap_val = carry_i ? {DATA_W{1'b1}} : sum_i;
`else
    cap_val = sum_i;
`endif
  end

  // Consume is applied before capture so a same-cycle capture lands in an
  // emptied word and never counts as an overwrite.
  always_comb begin
    data_d  = data_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    bits_v  = state_q;
    if (consume_i) begin
      bits_v = 2'b00;
      if (ready_q) cnt_d = cnt_q + 1'b1;
    end
    if (valid_i) begin
      if (bits_v[half_i]) err_d = 1'b1;
      if (carry_i)        ovf_d = 1'b1;
      bits_v[half_i] = 1'b1;
      if (half_i) data_d[MEM_WORD_SIZE-1:DATA_W] = cap_val;
      else        data_d[DATA_W-1:0]             = cap_val;
    end
    state_d = state_e'(bits_v);
    ready_d = (bits_v == FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign buff_result  = data_q;
  assign half_valid_o = state_q;
  assign word_ready_o = ready_q;
  assign ovf_sticky_o = ovf_q;
  assign err_sticky_o = err_q;
  assign word_count_o = cnt_q;

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer; expectations follow RESULT_BUF_CARRY_SAT_EN if defined.
module tb_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, valid_i, carry_i, half_i, consume_i;
  logic [31:0] sum_i;
  logic [63:0] buff_result;
  logic [1:0]  half_valid_o;
  logic        word_ready_o, ovf_sticky_o, err_sticky_o;
  logic [15:0] word_count_o;

  int total = 0;
  int bad   = 0;

  result_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
    .sum_i(sum_i), .carry_i(carry_i), .half_i(half_i), .consume_i(consume_i),
    .buff_result(buff_result), .half_valid_o(half_valid_o),
    .word_ready_o(word_ready_o), .ovf_sticky_o(ovf_sticky_o),
    .err_sticky_o(err_sticky_o), .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the currently driven inputs, then return them to idle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    rst_i = 0; clear_i = 0; valid_i = 0; consume_i = 0; carry_i = 0;
    half_i = 0; sum_i = '0;
  endtask

  task automatic cap(input logic h, input logic [31:0] s, input logic c);
    valid_i = 1; half_i = h; sum_i = s; carry_i = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".buf"},   buff_result, 64'h0);
    chk({tag, ".hv"},    {62'h0, half_valid_o}, 64'h0);
    chk({tag, ".ready"}, {63'h0, word_ready_o}, 64'h0);
    chk({tag, ".ovf"},   {63'h0, ovf_sticky_o}, 64'h0);
    chk({tag, ".err"},   {63'h0, err_sticky_o}, 64'h0);
    chk({tag, ".cnt"},   {48'h0, word_count_o}, 64'h0);
  endtask

  logic [31:0] carry_exp;

  initial begin
`ifdef RESULT_BUF_CARRY_SAT_EN
    carry_exp = 32'hFFFF_FFFF;
`else
    carry_exp = 32'h0000_0001;
`endif
    rst_i = 1; clear_i = 0; valid_i = 0; consume_i = 0; carry_i = 0;
    half_i = 0; sum_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1;
    tick();
    chk_all_zero("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.ready", {63'h0, word_ready_o}, 64'h0);
    end

    // Lower then upper, then consume.
    cap(0, 32'h0000_0003, 0); tick();
    chk("lo.hv", {62'h0, half_valid_o}, 64'h1);
    chk("lo.ready", {63'h0, word_ready_o}, 64'h0);
    chk("lo.buf", buff_result, 64'h0000_0000_0000_0003);
    cap(1, 32'h0000_0007, 0); tick();
    chk("hi.buf", buff_result, 64'h0000_0007_0000_0003);
    chk("hi.hv", {62'h0, half_valid_o}, 64'h3);
    chk("hi.ready", {63'h0, word_ready_o}, 64'h1);
    consume_i = 1; tick();
    chk("cons.hv", {62'h0, half_valid_o}, 64'h0);
    chk("cons.ready", {63'h0, word_ready_o}, 64'h0);
    chk("cons.cnt", {48'h0, word_count_o}, 64'h1);
    chk("cons.buf_kept", buff_result, 64'h0000_0007_0000_0003);
    chk("cons.err", {63'h0, err_sticky_o}, 64'h0);

    // Upper first.
    cap(1, 32'hAAAA_AAAA, 0); tick();
    chk("uf.hv", {62'h0, half_valid_o}, 64'h2);
    cap(0, 32'h5555_5555, 0); tick();
    chk("uf.buf", buff_result, 64'hAAAA_AAAA_5555_5555);
    chk("uf.ready", {63'h0, word_ready_o}, 64'h1);
    consume_i = 1; tick();
    chk("uf.cnt", {48'h0, word_count_o}, 64'h2);

    // Overwrite of lower half.
    cap(0, 32'h0000_0001, 0); tick();
    chk("ow1.err", {63'h0, err_sticky_o}, 64'h0);
    cap(0, 32'h0000_0002, 0); tick();
    chk("ow2.buf", buff_result, 64'hAAAA_AAAA_0000_0002);
    chk("ow2.err", {63'h0, err_sticky_o}, 64'h1);
    chk("ow2.hv", {62'h0, half_valid_o}, 64'h1);
    consume_i = 1; tick();
    chk("ow.cons_nocount", {48'h0, word_count_o}, 64'h2);
    chk("ow.cons_hv", {62'h0, half_valid_o}, 64'h0);
    chk("ow.err_sticky", {63'h0, err_sticky_o}, 64'h1);

    // Carry capture.
    chk("pre.ovf", {63'h0, ovf_sticky_o}, 64'h0);
    cap(0, 32'h0000_0001, 1); tick();
    chk("carry.buf", buff_result, {32'hAAAA_AAAA, carry_exp});
    chk("carry.ovf", {63'h0, ovf_sticky_o}, 64'h1);
    chk("carry.hv", {62'h0, half_valid_o}, 64'h1);

    // FULL, then simultaneous consume + capture upper.
    cap(1, 32'h0000_0005, 0); tick();
    chk("full.ready", {63'h0, word_ready_o}, 64'h1);
    cap(1, 32'h0000_0009, 0); consume_i = 1; tick();
    chk("sim.cnt", {48'h0, word_count_o}, 64'h3);
    chk("sim.hv", {62'h0, half_valid_o}, 64'h2);
    chk("sim.ready", {63'h0, word_ready_o}, 64'h0);
    chk("sim.upper", {32'h0, buff_result[63:32]}, 64'h9);
    chk("sim.lower", {32'h0, buff_result[31:0]}, {32'h0, carry_exp});
    chk("sim.ovf", {63'h0, ovf_sticky_o}, 64'h1);

    // Clear wins over a concurrent capture.
    clear_i = 1; cap(0, 32'h1234_5678, 1); tick();
    chk_all_zero("clear");

    // Reset mid-word discards the partial word.
    cap(0, 32'h0000_00FF, 0); tick();
    chk("mid.hv", {62'h0, half_valid_o}, 64'h1);
    rst_i = 1; cap(1, 32'h0000_00EE, 0); tick();
    chk_all_zero("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
